// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared widths, default FIFO depth, the buffered-result entry type, and a
// scoreboard lookup helper for the register-file write-back arbiter.
// ---------------------------------------------------------------------------
package rf_arb_pkg;

    localparam int REG_ADDR_W         = 5;
    localparam int XLEN               = 32;
    localparam int DEFAULT_FIFO_DEPTH = 2;

    // One MUL/DIV result waiting for a free register-file write slot.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } result_t;

    // Register 0 is hardwired to zero, so it can never be pending.
    function automatic logic sb_lookup(input logic [(1<<REG_ADDR_W)-1:0] sb,
                                       input logic [REG_ADDR_W-1:0]      addr);
        return (addr != '0) && sb[addr];
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// ---------------------------------------------------------------------------
// rf_wb_fifo
// Small result buffer between the MUL/DIV unit and the register-file port.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-low reset (clears pointers and count)
//   push_valid_i  entry offered for enqueue
//   push_ready_o  buffer not full (evaluated on current occupancy)
//   push_data_i   entry to enqueue
//   pop_i         remove head entry at the clock edge (ignored when empty)
//   count_o       occupancy, 0..DEPTH inclusive
//   head_o        oldest entry (meaningful only when count_o != 0)
// ---------------------------------------------------------------------------
import rf_arb_pkg::*;

module rf_wb_fifo #(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  result_t                    push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output result_t                    head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    result_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               push_fire;
    logic               pop_fire;

    // A full buffer refuses a push even if it pops this cycle.
    assign push_ready_o = (count_q != CNT_W'(DEPTH));
    assign push_fire    = push_valid_i & push_ready_o;
    assign pop_fire     = pop_i & (count_q != '0);

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Depth is a power of two, so pointer overflow is the modulo wrap.
        if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count decides which
    // entries are live, and a resettable array would cost a wide reset net.
    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port between the pipeline WB stage
// (absolute priority, zero latency) and buffered MUL/DIV results, and keeps
// a per-register pending scoreboard that stalls decode on RAW/WAW hazards.
//
// Ports:
//   clk, rst                    clock; synchronous active-low reset
//   wb_wr_en/addr/data          WB-stage write request
//   div_issue, div_issue_rd     MUL/DIV op issued from decode (marks pending)
//   div_valid/rd/data           result offered by the MUL/DIV unit
//   div_ready                   result accepted this cycle (buffer not full)
//   rs1_addr, rs2_addr, rd_addr decode-stage register fields
//   hazard_stall                decode depends on a pending MUL/DIV result
//   reg_file_wr_en/addr/data    register-file write port
// ---------------------------------------------------------------------------
import rf_arb_pkg::*;

module rf_wb_arbiter #(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_wr_addr,
    input  logic [XLEN-1:0]       wb_wr_data,
    input  logic                  div_issue,
    input  logic [REG_ADDR_W-1:0] div_issue_rd,
    input  logic                  div_valid,
    input  logic [REG_ADDR_W-1:0] div_rd,
    input  logic [XLEN-1:0]       div_data,
    output logic                  div_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  hazard_stall,
    output logic                  reg_file_wr_en,
    output logic [REG_ADDR_W-1:0] reg_file_wr_addr,
    output logic [XLEN-1:0]       reg_file_wr_data
);

    localparam int NREGS = 1 << REG_ADDR_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0] fifo_count;
    result_t          fifo_head;
    result_t          push_entry;
    logic             push_valid;
    logic             drain;
    logic [NREGS-1:0] pending_q, pending_d;

    // Results for x0 are accepted (div_ready still applies) but never stored.
    assign push_valid = div_valid & (div_rd != '0);
    assign push_entry = '{rd: div_rd, data: div_data};

    rf_wb_fifo #(
        .DEPTH        (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (push_valid),
        .push_ready_o (div_ready),
        .push_data_i  (push_entry),
        .pop_i        (drain),
        .count_o      (fifo_count),
        .head_o       (fifo_head)
    );

    // A WB request, even to x0, owns the port. Draining is suppressed while
    // reset is asserted so discarded results never reach the register file.
    assign drain = rst & ~wb_wr_en & (fifo_count != '0);

    always_comb begin
        reg_file_wr_en   = 1'b0;
        reg_file_wr_addr = '0;
        reg_file_wr_data = '0;
        if (wb_wr_en) begin
            reg_file_wr_en   = 1'b1;
            reg_file_wr_addr = wb_wr_addr;
            reg_file_wr_data = wb_wr_data;
        end else if (drain) begin
            reg_file_wr_en   = 1'b1;
            reg_file_wr_addr = fifo_head.rd;
            reg_file_wr_data = fifo_head.data;
        end
    end

    // Clear first, then set, so a re-issue in the drain cycle keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (drain) pending_d[fifo_head.rd] = 1'b0;
        if (div_issue && (div_issue_rd != '0)) pending_d[div_issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) pending_q <= '0;
        else      pending_q <= pending_d;
    end

    // Lookup uses the registered scoreboard: a register drained this cycle
    // still stalls decode until the next cycle.
    assign hazard_stall = sb_lookup(pending_q, rs1_addr)
                        | sb_lookup(pending_q, rs2_addr)
                        | sb_lookup(pending_q, rd_addr);

endmodule
